// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 32;

   localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction word store: one write port, one read port sampled on the clock edge.
module imem_ram
   import imem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Read and write share an edge; the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/imem_resp.sv
// Single-outstanding instruction fetch responder with wait states and fault detection.
// Optional fetch/error counters are built when IMEM_RESP_STATS_EN is defined.
module imem_resp
   import imem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_data,
   output logic              rsp_err,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data
`ifdef IMEM_RESP_STATS_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       err_cnt
`endif
);

   localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              err_reg, err_next;
   logic              dv_reg, dv_next;
   logic [WORD_W-1:0] ram_q;

   // Below-base addresses wrap to huge offsets and fall out of range naturally.
   logic [ADDR_W-1:0] req_word, ld_word;
   logic              req_fault, ld_ok, accept;

   assign req_word  = (req_addr - BASE_ADDR) >> 2;
   assign ld_word   = (ld_addr - BASE_ADDR) >> 2;
   assign req_fault = !is_word_aligned(req_addr) || (req_word >= 32'(DEPTH_WORDS));
   assign ld_ok     = ld_we && is_word_aligned(ld_addr) && (ld_word < 32'(DEPTH_WORDS));

   assign req_ready = (state_reg == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_err   = err_reg;
   assign rsp_data  = dv_reg ? (err_reg ? NOP_INSN : ram_q) : '0;

   imem_ram #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ld_ok),
      .waddr (ld_word[IDX_W-1:0]),
      .wdata (ld_data),
      .re    (accept),
      .raddr (req_word[IDX_W-1:0]),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         err_reg   <= 1'b0;
         dv_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         err_reg   <= err_next;
         dv_reg    <= dv_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      err_next   = err_reg;
      dv_next    = dv_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               err_next = req_fault;
               dv_next  = 1'b1;
               if (WAIT_LOAD == 4'd0) begin
                  state_next = ST_RESP;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg <= 4'd1) begin
               cnt_next   = 4'd0;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef IMEM_RESP_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt <= '0;
         err_cnt   <= '0;
      end else if (rsp_valid && rsp_ready) begin
         fetch_cnt <= fetch_cnt + 32'd1;
         if (err_reg)
            err_cnt <= err_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp (default geometry, one wait state).
module tb_imem_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        ld_we = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_data = '0;
`ifdef IMEM_RESP_STATS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] err_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   imem_resp #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
`ifdef IMEM_RESP_STATS_EN
      ,
      .fetch_cnt (fetch_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // Issue one fetch from a negedge; returns data/err seen when rsp_valid rises and the latency.
   task automatic fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat);
      int n;
      req_valid = 1'b1; req_addr = a;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk); n++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk); lat++;
      end
      d = rsp_data; e = rsp_err;
      if (!rsp_valid) begin
         lat = -1;
      end else if (rsp_ready) begin
         @(negedge clk);
      end
      $display("fetch addr=%08h data=%08h err=%0b lat=%0d", a, d, e, lat);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      vectors++; if (rsp_data !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got=%08h exp=00000000", rsp_data); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
      rst = 1'b0;
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
      $display("reset checked");
   endtask

   task automatic test_basic;
      logic [31:0] d; logic e; int lat;
      load_word(32'h0000_0000, 32'h0010_0093);
      load_word(32'h0000_0004, 32'hDEAD_BEEF);
      load_word(32'h0000_0FFC, 32'h1234_5678);
      fetch(32'h0000_0000, d, e, lat);
      vectors++; if (d !== 32'h0010_0093) begin miscompares++; $display("FAIL basic0_data got=%08h exp=00100093", d); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL basic0_err got=%b exp=0", e); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL basic0_latency got=%0d exp=2", lat); end
      fetch(32'h0000_0004, d, e, lat);
      vectors++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin miscompares++; $display("FAIL basic1 got=%08h/%b exp=deadbeef/0", d, e); end
      fetch(32'h0000_0FFC, d, e, lat);
      vectors++; if (d !== 32'h1234_5678 || e !== 1'b0) begin miscompares++; $display("FAIL basic_last got=%08h/%b exp=12345678/0", d, e); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle_after got=%b exp=1", req_ready); end
   endtask

   task automatic test_fault;
      logic [31:0] addrs [4];
      logic [31:0] d; logic e; int lat;
      addrs[0] = 32'h0000_0002; addrs[1] = 32'h0000_0001;
      addrs[2] = 32'h0000_1000; addrs[3] = 32'hFFFF_FFFC;
      // Out-of-range load must be dropped rather than alias word 0.
      load_word(32'h0000_1000, 32'hBAD0_BAD0);
      for (int i = 0; i < 4; i++) begin
         fetch(addrs[i], d, e, lat);
         vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL fault_err[%0d] got=%b exp=1", i, e); end
         vectors++; if (d !== 32'h0000_0013) begin miscompares++; $display("FAIL fault_data[%0d] got=%08h exp=00000013", i, d); end
      end
      fetch(32'h0000_0000, d, e, lat);
      vectors++; if (d !== 32'h0010_0093 || e !== 1'b0) begin miscompares++; $display("FAIL fault_no_alias got=%08h/%b exp=00100093/0", d, e); end
   endtask

   task automatic test_stall;
      logic [31:0] d; logic e; int lat;
      rsp_ready = 1'b0;
      fetch(32'h0000_0004, d, e, lat);
      vectors++; if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL stall_data got=%08h exp=deadbeef", d); end
      ld_we = 1'b1; ld_addr = 32'h0000_0004; ld_data = 32'h5555_AAAA;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ld_we = 1'b0;
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold[%0d] valid=%b data=%08h ready=%b exp=1/deadbeef/0", i, rsp_valid, rsp_data, req_ready);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
      fetch(32'h0000_0004, d, e, lat);
      vectors++; if (d !== 32'h5555_AAAA) begin miscompares++; $display("FAIL stall_late_load got=%08h exp=5555aaaa", d); end
   endtask

   task automatic test_same_edge;
      logic [31:0] d; logic e; int lat;
      load_word(32'h0000_0008, 32'hAAAA_0001);
      @(negedge clk);
      // Load and accept on the same edge for word 2.
      req_valid = 1'b1; req_addr = 32'h0000_0008;
      ld_we = 1'b1; ld_addr = 32'h0000_0008; ld_data = 32'hBBBB_0002;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; ld_we = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hAAAA_0001) begin miscompares++; $display("FAIL same_edge_old valid=%b data=%08h exp=1/aaaa0001", rsp_valid, rsp_data); end
      $display("same-edge fetch data=%08h", rsp_data);
      @(negedge clk);
      fetch(32'h0000_0008, d, e, lat);
      vectors++; if (d !== 32'hBBBB_0002) begin miscompares++; $display("FAIL same_edge_new got=%08h exp=bbbb0002", d); end
   endtask

   task automatic test_back_to_back;
      int acc [$];
      int n;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h0000_0000;
      for (int c = 0; c < 12; c++) begin
         if (req_ready) acc.push_back(c);
         @(negedge clk);
      end
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      $display("back-to-back accepts=%0d", acc.size());
      vectors++;
      if (acc.size() < 3) begin
         miscompares++; $display("FAIL b2b_count got=%0d exp>=3", acc.size());
      end else begin
         if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
            miscompares++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", acc[1] - acc[0], acc[2] - acc[1]);
         end
      end
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] d; logic e; int lat;
      logic seen;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_0000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      seen = rsp_valid;
      @(negedge clk);
      seen = seen | rsp_valid;
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midwait_ready got=%b exp=1", req_ready); end
`ifdef IMEM_RESP_STATS_EN
      vectors++; if (fetch_cnt !== 32'd0 || err_cnt !== 32'd0) begin miscompares++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", fetch_cnt, err_cnt); end
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL midwait_no_rsp got=%b exp=0", seen); end
      fetch(32'h0000_0000, d, e, lat);
      vectors++; if (d !== 32'h0010_0093) begin miscompares++; $display("FAIL mem_kept got=%08h exp=00100093", d); end
      $display("reset mid-wait checked");
   endtask

   task automatic test_stats;
`ifdef IMEM_RESP_STATS_EN
      logic [31:0] d; logic e; int lat;
      // One good fetch already consumed after the last reset.
      fetch(32'h0000_0004, d, e, lat);
      fetch(32'h0000_0FFC, d, e, lat);
      fetch(32'h0000_0006, d, e, lat);
      vectors++; if (fetch_cnt !== 32'd4) begin miscompares++; $display("FAIL stats_fetch got=%0d exp=4", fetch_cnt); end
      vectors++; if (err_cnt !== 32'd1) begin miscompares++; $display("FAIL stats_err got=%0d exp=1", err_cnt); end
      $display("stats fetch_cnt=%0d err_cnt=%0d", fetch_cnt, err_cnt);
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fault();
      test_stall();
      test_same_edge();
      test_back_to_back();
      test_reset_mid_wait();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit instruction words held.
REQ-002 The module SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0 (word-aligned).
REQ-003 The module SHALL have parameter WAIT_CYCLES, default 1, giving the extra wait states before a response (0..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  1  core fetch request present.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  fetch byte address (the core's pc).
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  core consumes the response this cycle.
REQ-011 rsp_data  output  32  fetched instruction word.
REQ-012 rsp_err  output  1  fetch fault (misaligned or out of range).
REQ-013 ld_we, ld_addr[31:0], ld_data[31:0]  inputs  program-load write port (bench preload).

Function
REQ-014 States SHALL be IDLE, WAIT and RESP; one request outstanding at most.
REQ-015 req_ready SHALL be 1 only in IDLE with rst low.
REQ-016 Handshake: request accepted on an edge where req_valid && req_ready; req_addr sampled only then.
REQ-017 On accept, rsp_data and rsp_err SHALL be registered from memory at that edge; later loads do not alter them.
REQ-018 Fault: req_addr[1:0] != 0 or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) -> rsp_err=1, rsp_data=32'h0000_0013 (NOP).
REQ-019 Word index SHALL be (req_addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction (below-base wraps high -> out of range).
REQ-020 WAIT_CYCLES=0: accept -> RESP directly, rsp_valid high the cycle after accept.
REQ-021 WAIT_CYCLES=k>0: accept -> WAIT, 4-bit down-counter loaded with k, RESP entered on the edge the counter reaches 0 (rsp_valid high k+1 cycles after accept).
REQ-022 In RESP, rsp_valid, rsp_data, rsp_err SHALL hold stable until rsp_valid && rsp_ready; that edge returns to IDLE.
REQ-023 Throughput: no accept in the cycle a response is consumed; back-to-back fetches are 2+WAIT_CYCLES cycles apart.
REQ-024 ld_we SHALL write ld_data to word (ld_addr-BASE_ADDR)>>2 in any state; out-of-range or misaligned load writes are dropped.
REQ-025 Same-edge load and accept to the same word: request returns the old (pre-write) data.
REQ-026 rsp_valid SHALL be 0 in IDLE and WAIT; rsp_data/rsp_err are don't-care when rsp_valid=0.

Reset
REQ-027 rst high SHALL immediately force state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, wait counter=0, counters=0.
REQ-028 Reset mid-WAIT or mid-RESP SHALL abandon the pending response without emitting it.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With IMEM_RESP_STATS_EN defined: outputs fetch_cnt[31:0] (responses consumed) and err_cnt[31:0] (consumed responses with rsp_err=1), each wrapping at 2^32; without it these ports and counters SHALL not exist.

Structure
REQ-031 Shared package imem_pkg SHALL hold the state enum, NOP constant 32'h0000_0013 and word/address width constants.
REQ-032 Storage SHALL be a sub-module imem_ram (one write port, one synchronous-sampled read port); FSM and fault logic remain in imem_resp.

Verification
REQ-033 Preload word 0=32'h0010_0093, WAIT_CYCLES=1; request addr 0, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=32'h0010_0093, rsp_err=0.
REQ-034 Request addr 32'h0000_0002 -> rsp_err=1, rsp_data=32'h0000_0013.
REQ-035 Request addr BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1; BASE_ADDR-4 -> rsp_err=1.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0; release -> IDLE next edge.
REQ-037 Assert rst mid-WAIT -> rsp_valid never rises, req_ready returns 1 the first cycle after rst deasserts; with IMEM_RESP_STATS_EN, 3 good + 1 fault fetches -> fetch_cnt=4, err_cnt=1.
